di_scan_ctrl: RTL and testbench

PLC input-scan controller for the synchronized digital-input bus. Filters each channel with a tick-based debounce, then on request sequences a scan: it waits for the inputs to go quiet, captures a coherent input image, and reports per-channel rising and falling edges since the previous scan. It sits between the input synchronizer and the register/CPU interface.

---
 rtl/di_scan_pkg.sv | 7 +
 rtl/di_debounce_ch.sv | 35 +++
 rtl/di_scan_ctrl.sv | 105 ++++++++++
 tb/tb_di_scan_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/di_scan_pkg.sv
// di_scan_pkg: shared scan FSM states and default widths for the digital-input scan controller.
package di_scan_pkg;
  localparam int WIDTH_DEF   = 32;
  localparam int DB_W_DEF    = 8;
  localparam int PRESC_W_DEF = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE} scan_st_e;
endpackage

// File: rtl/di_debounce_ch.sv
// di_debounce_ch: one input channel's tick-based debounce counter and filtered state.
module di_debounce_ch #(
  parameter int DB_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            raw,
  input  logic            tick,
  input  logic [DB_W-1:0] db_limit,
  output logic            filt,
  output logic            idle
);
  logic [DB_W-1:0] r_cnt;
  logic            r_filt;
  logic [DB_W:0]   w_nxt;
  logic            w_acc;
  assign w_nxt = {1'b0, r_cnt} + (DB_W+1)'(1);
  // a zero limit bypasses the tick so the filter simply follows one cycle late
  assign w_acc = db_limit == '0 || (tick && w_nxt >= {1'b0, db_limit});
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (raw == r_filt) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_filt <= raw;
      r_cnt  <= '0;
    end else if (tick) begin
      r_cnt <= w_nxt[DB_W-1:0];
    end
  end
  assign filt = r_filt;
  assign idle = r_cnt == '0 && raw == r_filt;
endmodule

// File: rtl/di_scan_ctrl.sv
// di_scan_ctrl: debounced input scan with settle wait, coherent capture and edge report.
// Defining DI_SCAN_IRQ_EN adds a sticky masked edge interrupt (irq_mask, irq_clr, irq).
module di_scan_ctrl
  import di_scan_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DB_W    = DB_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   di_status,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic [DB_W-1:0]    db_limit,
  input  logic               scan_req,
`ifdef DI_SCAN_IRQ_EN
  input  logic [WIDTH-1:0]   irq_mask,
  input  logic               irq_clr,
  output logic               irq,
`endif
  output logic               scan_busy,
  output logic               scan_done,
  output logic               scan_tmo,
  output logic [WIDTH-1:0]   di_filt,
  output logic [WIDTH-1:0]   di_image,
  output logic [WIDTH-1:0]   di_rise,
  output logic [WIDTH-1:0]   di_fall
);
  scan_st_e           r_st;
  logic [PRESC_W-1:0] r_pcnt;
  logic [DB_W:0]      r_stc;
  logic               r_tmo, r_scan_tmo;
  logic [WIDTH-1:0]   r_image, r_rise, r_fall;
  logic [WIDTH-1:0]   w_idle;
  logic               w_tick, w_quiet;
  logic [DB_W:0]      w_stc_nxt, w_lim1;
  assign w_tick    = r_pcnt >= presc_div;
  assign w_quiet   = &w_idle;
  assign w_stc_nxt = r_stc + (DB_W+1)'(1);
  assign w_lim1    = {1'b0, db_limit} + (DB_W+1)'(1);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    di_debounce_ch #(.DB_W(DB_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (di_status[i]),
      .tick     (w_tick),
      .db_limit (db_limit),
      .filt     (di_filt[i]),
      .idle     (w_idle[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt     <= '0;
      r_st       <= ST_IDLE;
      r_stc      <= '0;
      r_tmo      <= 1'b0;
      r_scan_tmo <= 1'b0;
      r_image    <= '0;
      r_rise     <= '0;
      r_fall     <= '0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
      case (r_st)
        ST_IDLE: if (scan_req) begin
          r_st  <= ST_SETTLE;
          r_stc <= '0;
        end
        // inputs that never go quiet are captured anyway after db_limit+1 ticks
        ST_SETTLE: if (w_quiet) begin
          r_st  <= ST_CAPTURE;
          r_tmo <= 1'b0;
        end else if (w_tick) begin
          r_stc <= w_stc_nxt;
          if (w_stc_nxt >= w_lim1) begin
            r_st  <= ST_CAPTURE;
            r_tmo <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          r_image    <= di_filt;
          r_rise     <= di_filt & ~r_image;
          r_fall     <= ~di_filt & r_image;
          r_scan_tmo <= r_tmo;
          r_st       <= ST_DONE;
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end
`ifdef DI_SCAN_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else r_irq <= (r_st == ST_DONE && |((r_rise | r_fall) & irq_mask)) || (r_irq && !irq_clr);
  end
  assign irq = r_irq;
`endif
  assign scan_busy = r_st == ST_SETTLE || r_st == ST_CAPTURE;
  assign scan_done = r_st == ST_DONE;
  assign scan_tmo  = r_scan_tmo;
  assign di_image  = r_image;
  assign di_rise   = r_rise;
  assign di_fall   = r_fall;
endmodule

// File: tb/tb_di_scan_ctrl.sv
// tb_di_scan_ctrl: directed stimulus with a cycle model of the scan rules checked every cycle.
module tb_di_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] di_status = 32'hFFFF_FFFF;
  logic [15:0] presc_div = 16'd0;
  logic [7:0]  db_limit = 8'd3;
  logic        scan_req = 1'b0;
  logic [31:0] irq_mask = 32'h1;
  logic        irq_clr = 1'b0;
  logic        scan_busy, scan_done, scan_tmo;
  logic [31:0] di_filt, di_image, di_rise, di_fall;
  int total = 0, bad = 0, done_cnt = 0, lat = 0;
  bit noise = 0;
`ifdef DI_SCAN_IRQ_EN
  logic irq;
`endif

  di_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .di_status (di_status),
    .presc_div (presc_div),
    .db_limit  (db_limit),
    .scan_req  (scan_req),
`ifdef DI_SCAN_IRQ_EN
    .irq_mask  (irq_mask),
    .irq_clr   (irq_clr),
    .irq       (irq),
`endif
    .scan_busy (scan_busy),
    .scan_done (scan_done),
    .scan_tmo  (scan_tmo),
    .di_filt   (di_filt),
    .di_image  (di_image),
    .di_rise   (di_rise),
    .di_fall   (di_fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for quiet, 2 capturing, 3 reporting
  bit [31:0] m_filt, m_image, m_rise, m_fall;
  int        m_cnt[32];
  int        m_pc, m_phase, m_ticks;
  bit        m_tick, m_quiet, m_tmo_pend, m_tmo, m_irq;

  always @(posedge clk) begin
    if (rst) begin
      m_filt = 0; m_image = 0; m_rise = 0; m_fall = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_pc = 0; m_phase = 0; m_ticks = 0; m_tmo_pend = 0; m_tmo = 0; m_irq = 0;
    end else begin
      m_tick  = m_pc >= int'(presc_div);
      m_quiet = di_status == m_filt;
      foreach (m_cnt[i]) if (m_cnt[i] != 0) m_quiet = 0;
      if (m_phase == 3 && ((m_rise | m_fall) & irq_mask) != 0) m_irq = 1;
      else if (irq_clr) m_irq = 0;
      case (m_phase)
        0: if (scan_req) begin m_phase = 1; m_ticks = 0; end
        1: if (m_quiet) begin
             m_phase = 2; m_tmo_pend = 0;
           end else if (m_tick) begin
             m_ticks++;
             if (m_ticks == int'(db_limit) + 1) begin m_phase = 2; m_tmo_pend = 1; end
           end
        2: begin
             m_rise = m_filt & ~m_image;
             m_fall = ~m_filt & m_image;
             m_image = m_filt;
             m_tmo = m_tmo_pend;
             m_phase = 3;
           end
        default: m_phase = 0;
      endcase
      for (int i = 0; i < 32; i++) begin
        if (di_status[i] == m_filt[i]) m_cnt[i] = 0;
        else if (db_limit == 0 || (m_tick && m_cnt[i] + 1 >= int'(db_limit))) begin
          m_filt[i] = di_status[i];
          m_cnt[i] = 0;
        end else if (m_tick) m_cnt[i]++;
      end
      m_pc = m_tick ? 0 : m_pc + 1;
    end
    #2;
    chk("busy", 32'(scan_busy), 32'(m_phase == 1 || m_phase == 2));
    chk("done", 32'(scan_done), 32'(m_phase == 3));
    chk("tmo", 32'(scan_tmo), 32'(m_tmo));
    chk("filt", di_filt, m_filt);
    chk("image", di_image, m_image);
    chk("rise", di_rise, m_rise);
    chk("fall", di_fall, m_fall);
`ifdef DI_SCAN_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  end

  task automatic cyc();
    @(negedge clk);
    if (scan_done) done_cnt++;
    if (noise) di_status[0] = m_pc != 5;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_scan(output int l);
    scan_req = 1'b1;
    l = 0;
    do begin
      cyc();
      l++;
      scan_req = 1'b0;
    end while (!scan_done && l < 100);
    chk("scan_wait", 32'(scan_done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    run(2);
    chk("rst_filt", di_filt, 32'h0);
    chk("rst_image", di_image, 32'h0);
    chk("rst_done", 32'(scan_done), 32'h0);
    chk("rst_busy", 32'(scan_busy), 32'h0);
    rst = 1'b0;
    run(2);
    chk("db3_early", di_filt, 32'h0);
    run(1);
    chk("db3_accept", di_filt, 32'hFFFF_FFFF);
    di_status = 32'h0;
    db_limit = 8'd0;
    run(2);
    do_scan(lat);
    run(2);
    di_status = 32'h20;
    run(2);
    do_scan(lat);
    chk("quiet_lat", 32'(lat), 32'd3);
    chk("b5_rise", di_rise, 32'h20);
    chk("b5_fall", di_fall, 32'h0);
    chk("b5_tmo", 32'(scan_tmo), 32'h0);
    run(2);
    presc_div = 16'd1;
    db_limit = 8'd4;
    di_status = 32'h24;
    run(6);
    di_status = 32'h20;
    run(4);
    chk("glitch_filt", di_filt, 32'h20);
    do_scan(lat);
    chk("glitch_rise", di_rise, 32'h0);
    chk("glitch_fall", di_fall, 32'h0);
    run(2);
    presc_div = 16'd9;
    db_limit = 8'd2;
    noise = 1;
    run(12);
    do_scan(lat);
    chk("noisy_tmo", 32'(scan_tmo), 32'h1);
    chk("noisy_lat_range", 32'(lat >= 23 && lat <= 32), 32'h1);
    run(2);
    done_cnt = 0;
    scan_req = 1'b1;
    cyc();
    scan_req = 1'b0;
    run(5);
    scan_req = 1'b1;
    cyc();
    scan_req = 1'b0;
    run(50);
    chk("one_done", 32'(done_cnt), 32'd1);
    done_cnt = 0;
    scan_req = 1'b1;
    cyc();
    scan_req = 1'b0;
    run(3);
    chk("settle_busy", 32'(scan_busy), 32'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_busy", 32'(scan_busy), 32'h0);
    run(40);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    noise = 0;
    di_status = 32'h20;
    presc_div = 16'd0;
    db_limit = 8'd0;
    run(3);
`ifdef DI_SCAN_IRQ_EN
    do_scan(lat);
    cyc();
    chk("irq_masked", 32'(irq), 32'h0);
    di_status = 32'h21;
    run(2);
    do_scan(lat);
    cyc();
    chk("irq_set", 32'(irq), 32'h1);
    di_status = 32'h20;
    run(2);
    scan_req = 1'b1;
    cyc();
    scan_req = 1'b0;
    run(2);
    chk("irq_done_cycle", 32'(scan_done), 32'h1);
    irq_clr = 1'b1;
    cyc();
    irq_clr = 1'b0;
    chk("irq_set_wins", 32'(irq), 32'h1);
    irq_clr = 1'b1;
    cyc();
    irq_clr = 1'b0;
    chk("irq_cleared", 32'(irq), 32'h0);
`endif
    run(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
